// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: bus widths, the MEM->WB bus field order,
// load opcode encoding and the WB->ID forwarding bus packer.
//
// Bus field orders:
//   WB->ID  (WB_TO_ID_WD  = 38): {wreg[37], waddr[36:32], wdata[31:0]}
//   MEM->WB (MEM_TO_WB_WD = 71): {valid[70], we[69], waddr[68:64], wdata[63:32], pc[31:0]}
package mem_wb_stage_pkg;

  localparam int unsigned WB_TO_ID_WD  = 38;
  localparam int unsigned MEM_TO_WB_WD = 71;

  localparam int unsigned WB_BUS_WREG_BIT = 37;

  // Load opcodes; 6 and 7 are undefined and treated as LdNone.
  typedef enum logic [2:0] {
    LdNone = 3'd0,
    LdLb   = 3'd1,
    LdLbu  = 3'd2,
    LdLh   = 3'd3,
    LdLhu  = 3'd4,
    LdLw   = 3'd5
  } load_op_e;

  function automatic logic [WB_TO_ID_WD-1:0] pack_wb_bus(input logic        wreg,
                                                         input logic [4:0]  waddr,
                                                         input logic [31:0] wdata);
    return {wreg, waddr, wdata};
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_ext.sv
// Load-data formatter: selects the addressed byte/halfword of the raw SRAM word and
// sign- or zero-extends it. Purely combinational.
//
// Ports:
//   load_op    in  3   load opcode (load_op_e encoding)
//   offset     in  2   byte offset within the word (effective address [1:0])
//   rdata      in  32  raw data-SRAM word
//   alu_result in  32  ALU result, passed through for non-loads
//   wdata      out 32  formatted writeback data
module mem_wb_stage_load_ext
  import mem_wb_stage_pkg::*;
(
  input  logic [2:0]  load_op,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [31:0] alu_result,
  output logic [31:0] wdata
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = 8'h00;
    unique case (offset)
      2'd0: sel_byte = rdata[7:0];
      2'd1: sel_byte = rdata[15:8];
      2'd2: sel_byte = rdata[23:16];
      2'd3: sel_byte = rdata[31:24];
      default: sel_byte = 8'h00;
    endcase
    // Misaligned halfword traps upstream, so offset[0] is ignored here.
    sel_half = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    wdata = alu_result;
    case (load_op)
      LdLb:    wdata = {{24{sel_byte[7]}}, sel_byte};
      LdLbu:   wdata = {24'h000000, sel_byte};
      LdLh:    wdata = {{16{sel_half[15]}}, sel_half};
      LdLhu:   wdata = {16'h0000, sel_half};
      LdLw:    wdata = rdata;
      default: wdata = alu_result;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load-data formatting ahead of the register. Drives the
// register-file write port and the WB->ID forwarding bus one cycle after MEM.
// Optional trace outputs are enabled by defining MEM_WB_DEBUG_TRACE_EN.
//
// Ports:
//   clk, resetn           core clock (rising edge), async active-low reset
//   stall_wb, flush_wb    hold / bubble controls (flush has priority)
//   mem_*                 MEM-stage instruction results
//   rf_we/waddr/wdata     register-file write port
//   wb_to_id_bus          {rf_we, rf_waddr, rf_wdata} forwarding bus
//   debug_wb_*            trace outputs (MEM_WB_DEBUG_TRACE_EN only)
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   stall_wb,
  input  logic                   flush_wb,
  input  logic                   mem_valid,
  input  logic [31:0]            mem_pc,
  input  logic                   mem_rf_we,
  input  logic [4:0]             mem_rf_waddr,
  input  logic [31:0]            mem_alu_result,
  input  logic [2:0]             mem_load_op,
  input  logic [31:0]            mem_load_rdata,
  output logic                   rf_we,
  output logic [4:0]             rf_waddr,
  output logic [31:0]            rf_wdata,
  output logic [WB_TO_ID_WD-1:0] wb_to_id_bus
`ifdef MEM_WB_DEBUG_TRACE_EN
  ,
  output logic [31:0]            debug_wb_pc,
  output logic [3:0]             debug_wb_rf_wen,
  output logic [4:0]             debug_wb_rf_wnum,
  output logic [31:0]            debug_wb_rf_wdata
`endif
);

  logic [31:0] fmt_wdata;

  logic        valid_q, valid_d;
  logic        we_q, we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;

  mem_wb_stage_load_ext u_load_ext (
    .load_op    (mem_load_op),
    .offset     (mem_alu_result[1:0]),
    .rdata      (mem_load_rdata),
    .alu_result (mem_alu_result),
    .wdata      (fmt_wdata)
  );

  // Bubbles only clear valid/we; address and data are left stale.
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (flush_wb) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
    end else if (!stall_wb) begin
      if (mem_valid) begin
        valid_d = 1'b1;
        we_d    = mem_rf_we;
        waddr_d = mem_rf_waddr;
        wdata_d = fmt_wdata;
      end else begin
        valid_d = 1'b0;
        we_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // $0 is hardwired; never drive a write (or a forward) to it.
  assign rf_we        = valid_q & we_q & (waddr_q != 5'd0);
  assign rf_waddr     = waddr_q;
  assign rf_wdata     = wdata_q;
  assign wb_to_id_bus = pack_wb_bus(rf_we, rf_waddr, rf_wdata);

`ifdef MEM_WB_DEBUG_TRACE_EN
  logic [31:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (!flush_wb && !stall_wb && mem_valid) begin
      pc_d = mem_pc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q <= 32'd0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`else
  logic unused_mem_pc;
  assign unused_mem_pc = ^mem_pc;
`endif

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback formatting for the 5-stage MIPS core.
- Captures MEM-stage results and does load-data byte/half extraction before the register.
- Drives the register-file write port (we/waddr/wdata) and the WB→ID forwarding bus consumed by the register-file read bypass.
- Outputs are registered, so the write reaches the register file one cycle after MEM.

Parameters:
- WB_TO_ID_WD, 38, forwarding bus width {wreg[37], waddr[36:32], wdata[31:0]}; value comes from the shared package.

Ports:
- clk  in  1  core clock, rising edge
- resetn  in  1  asynchronous active-low reset
- stall_wb  in  1  hold WB register contents (from pipeline ctrl)
- flush_wb  in  1  insert bubble (exception/flush from ctrl)
- mem_valid  in  1  MEM stage holds a valid instruction this cycle
- mem_pc  in  32  PC of MEM instruction
- mem_rf_we  in  1  instruction writes a GPR
- mem_rf_waddr  in  5  destination GPR
- mem_alu_result  in  32  ALU result, or effective address for loads
- mem_load_op  in  3  LD_NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5
- mem_load_rdata  in  32  raw data-SRAM word returned this cycle
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- wb_to_id_bus  out  WB_TO_ID_WD  {rf_we, rf_waddr, rf_wdata}, same values as the write port

Behaviour:
- Async reset (resetn=0): valid, we, waddr, wdata and pc all clear to 0 immediately, with no clock required. The bus reads 0. Normal operation resumes on the first rising edge after deassertion.
- Register update at posedge clk, in priority order:
  - flush_wb=1 → bubble (valid=0, we=0). Flush beats stall.
  - else stall_wb=1 → hold all fields unchanged; outputs stay stable.
  - else mem_valid=1 → capture the formatted MEM result.
  - else → bubble.
- Formatted data (combinational, before the register):
  - The byte offset is taken from mem_alu_result[1:0].
  - LW: the full word.
  - LB/LBU: the selected byte (offset 0→[7:0], 1→[15:8], 2→[23:16], 3→[31:24]). LB sign-extends it; LBU zero-extends it.
  - LH/LHU: offset[1]=0→[15:0], 1→[31:16]. LH sign-extends; LHU zero-extends. offset[0] is ignored (the exception is raised upstream).
  - LD_NONE: mem_alu_result.
  - Undefined load_op codes 6-7 behave as LD_NONE.
- Write enable: rf_we = valid & captured_we & (waddr != 0). A write to $0 is never driven, and its bus entry carries wreg=0.
- Latency: MEM data reaches the write port exactly 1 cycle after capture. The register file writes at the following edge, so the ID-stage bypass must cover this cycle through wb_to_id_bus.
- Stall: the write port stays asserted for every held cycle. Rewriting the same value is harmless and required, because forwarding must stay valid.
- Bubble: rf_waddr and rf_wdata may hold stale values, but rf_we=0 and the bus wreg=0.

Optional Feature:
- Macro: MEM_WB_DEBUG_TRACE_EN.
- When defined, adds outputs:
  - debug_wb_pc[31:0]: registered pc
  - debug_wb_rf_wen[3:0]: {4{rf_we}}
  - debug_wb_rf_wnum[4:0]: rf_waddr
  - debug_wb_rf_wdata[31:0]: rf_wdata
- These outputs follow the same reset, stall and flush rules. They are used for trace comparison against the golden model.
- When not defined, the ports are absent and the pc register is not instantiated. Functional outputs are identical either way.

Decomposition:
- defines.vh holds:
  - WB_TO_ID_WD (38) and MEM_TO_WB_WD
  - the LD_* opcode constants
  - the bus field order
- Sub-module load_ext: purely combinational. Inputs are load_op, offset[1:0], rdata and alu_result; output is the formatted data. It is tested standalone.

Test Plan:
- Reset: assert resetn=0 mid-run with captured we=1, waddr=8 → rf_we=0 and bus=38'h0 immediately, without a clock edge.
- LB/LBU: rdata=32'h12F4_5678, addr=...02, waddr=9 → LB writes 32'hFFFF_FFF4 and LBU writes 32'h0000_00F4 to $9 one cycle after capture.
- LH/LHU: rdata=32'h8001_7FFF, addr[1]=1 → LH gives 32'hFFFF_8001 and LHU gives 32'h0000_8001. With addr[1]=0, LH gives 32'h0000_7FFF.
- $0 suppression: mem_rf_we=1, waddr=0, result=32'hDEAD_BEEF → rf_we=0 and bus[37]=0.
- Stall then flush: capture ALU result 32'h0000_0042 to $3, then stall_wb=1 for 3 cycles → outputs stay constant with rf_we=1. Then assert flush_wb and stall_wb together → next cycle rf_we=0.
- Back-to-back: three consecutive valid ALU ops to $4, $5, $4 → bus shows each in order, one per cycle, with no drops.
